uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver, the parametrised successor to the single-tick receiver. It samples the serial line at `OVERSAMPLE` × baud and captures each bit at mid-bit. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits, and reports parity and framing errors. It sits between the pad-side `rx_line` and the byte-level consumer (FIFO or register interface), driven by a shared oversample tick generator.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5–9; sent LSB first.
- `OVERSAMPLE`, 16, `os_tick` pulses per bit time; even value, ≥ 4.
- `PARITY_MODE`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits: 1 or 2.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `os_tick`  in  1  1-cycle pulse at `OVERSAMPLE` × baud.
- `rx_line`  in  1  asynchronous UART input; idle high.
- `data_out`  out  `DATA_BITS`  last received word; holds until the next frame completes.
- `valid`  out  1  1-cycle pulse when a frame completes.
- `parity_err`  out  1  parity mismatch; meaningful only while `valid`=1; forced 0 when `PARITY_MODE`=0.
- `frame_err`  out  1  a stop bit sampled low; meaningful only while `valid`=1.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchroniser: `rx_line` passes through a 2-FF synchroniser; both flops reset to 1. The FSM sees only the synchronised value `rxs`.
- Bit-time counter `cnt`, width clog2(`OVERSAMPLE`):
  - Advances only on `os_tick`.
  - Clears on every state change.
- Bit counter: counts `DATA_BITS` data bits, then `STOP_BITS` stop bits.
- FSM states:
  - IDLE: `cnt`=0. On `rxs`=0 → START.
  - START: on the `os_tick` where `cnt` = `OVERSAMPLE`/2−1 (mid start bit), sample `rxs`.
    - If 0 → DATA.
    - If 1 → IDLE (false start; no outputs change).
  - DATA: on the `os_tick` where `cnt` = `OVERSAMPLE`−1, sample `rxs` into the shift register at the current bit index and clear `cnt`.
    - After bit `DATA_BITS`−1 → PARITY if `PARITY_MODE`≠0, else STOP.
  - PARITY: sample one bit at the same point.
    - Odd mode: error if XOR(data, bit) ≠ 1.
    - Even mode: error if XOR(data, bit) ≠ 0.
    - → STOP.
  - STOP: sample `STOP_BITS` bits at the same point; any low sample sets the frame-error flag.
    - After the last stop sample, in the same cycle:
      - Load `data_out`.
      - Pulse `valid`.
      - Drive `parity_err` and `frame_err`.
    - If no frame error → IDLE; if frame error → WAIT_HIGH.
  - WAIT_HIGH (break/line-stuck guard): stay until `rxs`=1, then → IDLE. No new frame starts while the line is held low.
- Error frames still deliver: `data_out` is updated and `valid` pulses; the consumer decides whether to drop the word.
- Reset values: `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0, synchroniser=11.
- Reset mid-frame aborts the frame immediately and emits no `valid`.

## Timing
- Line edge to IDLE→START: 2–3 clk (synchroniser latency).
- Sample point: all samples fall `OVERSAMPLE`/2 ticks after the detected falling edge, plus integer multiples of `OVERSAMPLE` ticks (±1 tick of edge-detect jitter).
- `valid` asserts on the clk edge that registers the last stop-bit sample. This is 1 clk after that `os_tick` is seen, with `os_tick` registered into the FSM in the same cycle.
- `valid` is high for exactly 1 clk.
- `parity_err` and `frame_err` are 1-clk pulses coincident with `valid`, and 0 at all other times.
- Back-to-back frames: the START detection window opens on the first clk in IDLE after the last stop sample. A start bit that immediately follows the stop bit is caught.
- `os_tick` asserted for consecutive clks is legal; each cycle counts as one tick.
- No `os_tick` means the FSM holds state indefinitely.
- `busy` rises with the IDLE→START transition and falls on entry to IDLE.

## Test plan
- 8N1, `OVERSAMPLE`=16: send 0xA5 → one `valid` pulse, `data_out`=0xA5, `parity_err`=0, `frame_err`=0, `busy` low after the stop bit.
- Glitch: drive `rx_line` low for 4 `os_tick`s, then high → START aborts at mid-bit, no `valid`, `busy` returns to 0, `data_out` unchanged.
- `PARITY_MODE`=2 (even): send 0x37 with parity bit 1 → `parity_err`=0. Send 0x37 with parity bit 0 → `valid` with `data_out`=0x37 and `parity_err`=1.
- Stop bit driven low, then line held low for 40 bit times → `valid` with `frame_err`=1, no further `valid` while low. After the line returns high, send 0x5A → received correctly.
- Reset mid-frame: assert `rst` after 3 data bits of 0xC3 → all outputs 0 immediately. Then send 0x3C → `data_out`=0x3C, exactly one `valid`.
- Back-to-back 0x00 then 0xFF with `STOP_BITS`=2, `DATA_BITS`=7 → two `valid` pulses, `data_out`=0x00 then 0x7F, no errors.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os_if
// Bundle of the serial-side and byte-side signals of the oversampling UART
// receiver. The receiver connects through the slave modport; the block that
// feeds the line and tick and consumes received words uses the master modport.
//
//   os_tick    : oversample tick pulse (OVERSAMPLE x baud)
//   rx_line    : asynchronous serial input, idle high
//   data_out   : last received word, held until the next frame completes
//   valid      : 1-clk pulse when a frame completes
//   parity_err : parity mismatch, qualified by valid
//   frame_err  : low stop bit seen, qualified by valid
//   busy       : receiver is inside a frame (FSM not idle)
// -----------------------------------------------------------------------------
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic                 os_tick;
  logic                 rx_line;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output os_tick,
    output rx_line,
    input  data_out,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  os_tick,
    input  rx_line,
    output data_out,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver. The line is synchronised, a falling edge opens
// a frame, the start bit is confirmed at mid-bit and every following bit is
// sampled one full bit time later. Supports 5..9 data bits (LSB first), no /
// odd / even parity and 1 or 2 stop bits. Frames with errors are still
// delivered; the error flags are pulsed together with valid.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_rx_os_if.slave (os_tick, rx_line in; data_out, valid,
//          parity_err, frame_err, busy out)
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_os_if.slave  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Tick positions of the start-bit midpoint and of every later bit midpoint.
  localparam logic [CW-1:0] HALF_C = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_C = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA_C = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP_C = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // Parity check of a received word against its parity bit.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic par_bit);
    logic x;
    x = (^data) ^ par_bit;
    case (PARITY_MODE)
      1:       return (x != 1'b1);
      2:       return (x != 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  state_t               state_r, state_s;
  logic                 rx_meta_r, rxs_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 ferr_r;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 valid_r, parity_err_r, frame_err_r, busy_r;

  logic mid_tick_s, bit_tick_s, frame_done_s, ferr_s;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx_line;
      rxs_r     <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and frame-completion strobe.
  always_comb begin
    state_s      = state_r;
    mid_tick_s   = bus.os_tick && (cnt_r == HALF_C);
    bit_tick_s   = bus.os_tick && (cnt_r == LAST_C);
    // A low sample on the final stop bit counts toward the error reported now.
    ferr_s       = ferr_r | ~rxs_r;
    frame_done_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rxs_r) state_s = S_START;
        else        state_s = S_IDLE;
      end
      S_START: begin
        if (mid_tick_s) state_s = rxs_r ? S_IDLE : S_DATA;
        else            state_s = S_START;
      end
      S_DATA: begin
        if (bit_tick_s && (bit_cnt_r == LAST_DATA_C))
          state_s = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        else
          state_s = S_DATA;
      end
      S_PARITY: begin
        if (bit_tick_s) state_s = S_STOP;
        else            state_s = S_PARITY;
      end
      S_STOP: begin
        if (bit_tick_s && (bit_cnt_r == LAST_STOP_C)) begin
          frame_done_s = 1'b1;
          state_s      = ferr_s ? S_WAIT_HIGH : S_IDLE;
        end else begin
          state_s = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        // A stuck-low line after a framing error must not open a new frame.
        if (rxs_r) state_s = S_IDLE;
        else       state_s = S_WAIT_HIGH;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Counters, shift register, error tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= CW'(0);
      bit_cnt_r    <= BW'(0);
      shift_r      <= DATA_BITS'(0);
      par_bit_r    <= 1'b0;
      ferr_r       <= 1'b0;
      data_out_r   <= DATA_BITS'(0);
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= (state_s != S_IDLE);

      // Bit-time counter: restarts on every state change and after each
      // mid-bit sample, so it always measures from the last sample point.
      if ((state_s != state_r) || (state_r == S_IDLE) || (state_r == S_WAIT_HIGH))
        cnt_r <= CW'(0);
      else if (bit_tick_s)
        cnt_r <= CW'(0);
      else if (bus.os_tick)
        cnt_r <= cnt_r + CW'(1);

      if (state_s != state_r)
        bit_cnt_r <= BW'(0);
      else if (bit_tick_s)
        bit_cnt_r <= bit_cnt_r + BW'(1);

      // LSB arrives first, so shifting in from the top leaves it at bit 0.
      if ((state_r == S_DATA) && bit_tick_s)
        shift_r <= {rxs_r, shift_r[DATA_BITS-1:1]};

      if ((state_r == S_PARITY) && bit_tick_s)
        par_bit_r <= rxs_r;

      if (state_r == S_START)
        ferr_r <= 1'b0;
      else if ((state_r == S_STOP) && bit_tick_s && !rxs_r)
        ferr_r <= 1'b1;

      if (frame_done_s) begin
        data_out_r   <= shift_r;
        valid_r      <= 1'b1;
        parity_err_r <= parity_error(shift_r, par_bit_r);
        frame_err_r  <= ferr_s;
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.valid      = valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Three receiver instances: 8N1, 8E1 and 7N2, all at OVERSAMPLE=16 with one
// os_tick every 4 clocks. Stimulus pushes expected frames into per-instance
// queues; monitors pop and compare on every valid pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic os_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  int   div = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;

  uart_rx_os_if #(.DATA_BITS(8)) if_a ();
  uart_rx_os_if #(.DATA_BITS(8)) if_b ();
  uart_rx_os_if #(.DATA_BITS(7)) if_c ();

  assign if_a.os_tick = os_tick;
  assign if_b.os_tick = os_tick;
  assign if_c.os_tick = os_tick;
  assign if_a.rx_line = rx_a;
  assign if_b.rx_line = rx_b;
  assign if_c.rx_line = rx_c;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  // Tick changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    div     = (div == 3) ? 0 : div + 1;
    os_tick = (div == 0);
  end

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = f;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // One frame: start, nbits data LSB first, optional parity (par < 0: none),
  // nstop stop bits at level stop_v. The line is left at stop_v.
  task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                            input int par, input int nstop, input logic stop_v);
    set_rx(inst, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(inst, d[i]);
      wait_ticks(16);
    end
    if (par >= 0) begin
      set_rx(inst, (par != 0));
      wait_ticks(16);
    end
    set_rx(inst, stop_v);
    wait_ticks(16 * nstop);
  endtask

  // Scoreboard monitor, instance a.
  always @(negedge clk) begin
    if (!rst && if_a.valid) begin
      if (q_a.size() == 0) flag_fail("a_unexpected_valid", 32'(if_a.data_out));
      else begin
        e_a = q_a.pop_front();
        check("a_data", 32'(if_a.data_out), 32'(e_a.data));
        check("a_parity_err", 32'(if_a.parity_err), 32'(e_a.perr));
        check("a_frame_err", 32'(if_a.frame_err), 32'(e_a.ferr));
      end
    end
    if (!rst && !if_a.valid && (if_a.parity_err || if_a.frame_err))
      flag_fail("a_err_without_valid", {30'd0, if_a.parity_err, if_a.frame_err});
  end

  // Scoreboard monitor, instance b.
  always @(negedge clk) begin
    if (!rst && if_b.valid) begin
      if (q_b.size() == 0) flag_fail("b_unexpected_valid", 32'(if_b.data_out));
      else begin
        e_b = q_b.pop_front();
        check("b_data", 32'(if_b.data_out), 32'(e_b.data));
        check("b_parity_err", 32'(if_b.parity_err), 32'(e_b.perr));
        check("b_frame_err", 32'(if_b.frame_err), 32'(e_b.ferr));
      end
    end
    if (!rst && !if_b.valid && (if_b.parity_err || if_b.frame_err))
      flag_fail("b_err_without_valid", {30'd0, if_b.parity_err, if_b.frame_err});
  end

  // Scoreboard monitor, instance c.
  always @(negedge clk) begin
    if (!rst && if_c.valid) begin
      if (q_c.size() == 0) flag_fail("c_unexpected_valid", 32'(if_c.data_out));
      else begin
        e_c = q_c.pop_front();
        check("c_data", 32'(if_c.data_out), 32'(e_c.data));
        check("c_parity_err", 32'(if_c.parity_err), 32'(e_c.perr));
        check("c_frame_err", 32'(if_c.frame_err), 32'(e_c.ferr));
      end
    end
    if (!rst && !if_c.valid && (if_c.parity_err || if_c.frame_err))
      flag_fail("c_err_without_valid", {30'd0, if_c.parity_err, if_c.frame_err});
  end

  // Watchdog: the stimulus is tick-driven and bounded, this only guards hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(if_a.data_out), 32'h0);
    check("rst_valid", 32'(if_a.valid), 32'h0);
    check("rst_busy", 32'(if_a.busy), 32'h0);
    check("rst_errs", {30'd0, if_a.parity_err, if_a.frame_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(32);

    // 8N1: 0xA5.
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
    #1;
    check("a5_busy_after_stop", 32'(if_a.busy), 32'h0);
    wait_ticks(16);

    // Glitch: 4 ticks low, then high; start is rejected at mid-bit.
    rx_a = 1'b0;
    wait_ticks(4);
    #1;
    check("glitch_busy_during", 32'(if_a.busy), 32'h1);
    rx_a = 1'b1;
    wait_ticks(16);
    #1;
    check("glitch_busy_after", 32'(if_a.busy), 32'h0);
    check("glitch_data_held", 32'(if_a.data_out), 32'hA5);
    wait_ticks(16);

    // Framing error, then line held low for 40 bit times.
    q_a.push_back(mk(9'h081, 1'b0, 1'b1));
    send_frame(0, 9'h081, 8, -1, 1, 1'b0);
    wait_ticks(16 * 40);
    #1;
    check("break_busy_held", 32'(if_a.busy), 32'h1);
    check("break_data_held", 32'(if_a.data_out), 32'h81);
    rx_a = 1'b1;
    wait_ticks(32);
    q_a.push_back(mk(9'h05A, 1'b0, 1'b0));
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1);
    wait_ticks(32);
    check("break_queue_drained", 32'(q_a.size()), 32'h0);

    // Reset in the middle of 0xC3 after three data bits (1,1,0).
    rx_a = 1'b0; wait_ticks(16);
    rx_a = 1'b1; wait_ticks(16);
    rx_a = 1'b1; wait_ticks(16);
    rx_a = 1'b0; wait_ticks(8);
    rst = 1'b1;
    #1;
    check("midrst_data_out", 32'(if_a.data_out), 32'h0);
    check("midrst_busy", 32'(if_a.busy), 32'h0);
    check("midrst_valid", 32'(if_a.valid), 32'h0);
    rx_a = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(32);
    q_a.push_back(mk(9'h03C, 1'b0, 1'b0));
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1);
    wait_ticks(32);

    // Even parity: 0x37 has five ones, so parity bit 1 is correct.
    q_b.push_back(mk(9'h037, 1'b0, 1'b0));
    send_frame(1, 9'h037, 8, 1, 1, 1'b1);
    wait_ticks(32);
    q_b.push_back(mk(9'h037, 1'b1, 1'b0));
    send_frame(1, 9'h037, 8, 0, 1, 1'b1);
    wait_ticks(32);

    // 7N2 back-to-back: 0x00 then 0xFF (seven bits received as 0x7F).
    q_c.push_back(mk(9'h000, 1'b0, 1'b0));
    q_c.push_back(mk(9'h07F, 1'b0, 1'b0));
    send_frame(2, 9'h000, 7, -1, 2, 1'b1);
    send_frame(2, 9'h0FF, 7, -1, 2, 1'b1);
    wait_ticks(32);

    check("a_frames_all_seen", 32'(q_a.size()), 32'h0);
    check("b_frames_all_seen", 32'(q_b.size()), 32'h0);
    check("c_frames_all_seen", 32'(q_c.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
